// File: rtl/average_calculator.sv
// Two-stage pipelined mean of four unsigned operands.
// Stage 1 forms pairwise sums; stage 2 adds them and divides by four (floor or round-half-up).
module average_calculator #(
   parameter int WIDTH = 8,
   parameter bit ROUND = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   c,
   input  logic [WIDTH-1:0]   d,
   output logic               out_valid,
   output logic [WIDTH-1:0]   avg,
   output logic [WIDTH+1:0]   sum
);

   logic               v1_q;
   logic [WIDTH:0]     sAb_q, sAb_d;
   logic [WIDTH:0]     sCd_q, sCd_d;
   logic               outValid_q;
   logic [WIDTH+1:0]   sum_q, sum_d;
   logic [WIDTH-1:0]   avg_q, avg_d;
   logic [WIDTH+1:0]   sumRounded;

   always_comb begin
      sAb_d = {1'b0, a} + {1'b0, b};
      sCd_d = {1'b0, c} + {1'b0, d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q  <= 1'b0;
         sAb_q <= '0;
         sCd_q <= '0;
      end else begin
         v1_q <= in_valid;
         if (in_valid) begin
            sAb_q <= sAb_d;
            sCd_q <= sCd_d;
         end
      end
   end

   // The +2 cannot carry out of WIDTH+2 bits: the largest sum plus two still fits.
   always_comb begin
      sum_d      = {1'b0, sAb_q} + {1'b0, sCd_q};
      sumRounded = sum_d + (WIDTH+2)'(2);
      avg_d      = ROUND ? sumRounded[WIDTH+1:2] : sum_d[WIDTH+1:2];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid_q <= 1'b0;
         sum_q      <= '0;
         avg_q      <= '0;
      end else begin
         outValid_q <= v1_q;
         if (v1_q) begin
            sum_q <= sum_d;
            avg_q <= avg_d;
         end
      end
   end

   assign out_valid = outValid_q;
   assign sum       = sum_q;
   assign avg       = avg_q;

endmodule

// File: tb/tb_average_calculator.sv
// Bench for average_calculator: directed vectors on 8-bit floor/round instances sharing inputs,
// plus a random run that also drives a 12-bit rounding instance, all checked two edges later.
module tb_average_calculator;

   typedef struct {
      bit v;
      int sum;
      int avg0;
      int avg1;
      bit v12;
      int sum12;
      int avg12;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inValid = 1'b0;
   logic [7:0]  a = '0, b = '0, c = '0, d = '0;
   logic        inValid12 = 1'b0;
   logic [11:0] a12 = '0, b12 = '0, c12 = '0, d12 = '0;

   logic        outValid0, outValid1, outValid12;
   logic [7:0]  avg0, avg1;
   logic [9:0]  sum0, sum1;
   logic [11:0] avg12;
   logic [13:0] sum12;

   int checkCount = 0;
   int passCount  = 0;

   exp_t d1, d2, none;
   int heldSum, heldAvg0, heldAvg1, heldSum12, heldAvg12;

   average_calculator #(.WIDTH(8), .ROUND(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid), .a(a), .b(b), .c(c), .d(d),
      .out_valid(outValid0), .avg(avg0), .sum(sum0));

   average_calculator #(.WIDTH(8), .ROUND(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid), .a(a), .b(b), .c(c), .d(d),
      .out_valid(outValid1), .avg(avg1), .sum(sum1));

   average_calculator #(.WIDTH(12), .ROUND(1'b1)) dut12 (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid12), .a(a12), .b(b12), .c(c12), .d(d12),
      .out_valid(outValid12), .avg(avg12), .sum(sum12));

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checkCount++;
      if (observed == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
   endtask

   // Forget everything in flight; outputs read zero after reset until the next valid result.
   task automatic clearModel();
      none = '{default: 0};
      d1 = none;
      d2 = none;
      heldSum = 0; heldAvg0 = 0; heldAvg1 = 0; heldSum12 = 0; heldAvg12 = 0;
   endtask

   // At each falling edge: check the result of the set driven two falling edges ago, then drive a new set.
   task automatic applyStimulus(input logic [7:0] av, bv, cv, dv, input logic [11:0] a2, b2, c2, d2v,
                                input exp_t e);
      exp_t r;
      @(negedge clk);
      r = d2;
      if (r.v)   begin heldSum = r.sum; heldAvg0 = r.avg0; heldAvg1 = r.avg1; end
      if (r.v12) begin heldSum12 = r.sum12; heldAvg12 = r.avg12; end
      checkOutput("outValid8", outValid0, r.v);
      checkOutput("outValid8r", outValid1, r.v);
      checkOutput("sum8", sum0, heldSum);
      checkOutput("sum8r", sum1, heldSum);
      checkOutput("avgFloor8", avg0, heldAvg0);
      checkOutput("avgRound8", avg1, heldAvg1);
      checkOutput("outValid12", outValid12, r.v12);
      checkOutput("sum12", sum12, heldSum12);
      checkOutput("avgRound12", avg12, heldAvg12);
      d2 = d1;
      d1 = e;
      inValid = e.v;
      a = av; b = bv; c = cv; d = dv;
      inValid12 = e.v12;
      a12 = a2; b12 = b2; c12 = c2; d12 = d2v;
   endtask

   task automatic directed(input bit v, input logic [7:0] av, bv, cv, dv, input int s, f, r);
      exp_t e;
      e = '{v: v, sum: s, avg0: f, avg1: r, v12: 1'b0, sum12: 0, avg12: 0};
      applyStimulus(av, bv, cv, dv, 12'd0, 12'd0, 12'd0, 12'd0, e);
   endtask

   initial begin
      exp_t e;
      int s8, s12;
      logic [7:0] ra, rb, rc, rd;
      logic [11:0] qa, qb, qc, qd;
      clearModel();

      #1;
      checkOutput("rstInitValid", outValid0, 0);
      checkOutput("rstInitSum", sum0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Hand-computed vectors: sum, floor(sum/4), (sum+2)>>2.
      directed(1, 8'd10,  8'd20,  8'd30,  8'd40,  100,  25,  25);
      directed(1, 8'd100, 8'd150, 8'd200, 8'd250, 700,  175, 175);
      directed(1, 8'd0,   8'd0,   8'd0,   8'd0,   0,    0,   0);
      directed(1, 8'd255, 8'd255, 8'd255, 8'd255, 1020, 255, 255);
      directed(1, 8'd1,   8'd1,   8'd1,   8'd0,   3,    0,   1);
      directed(1, 8'd255, 8'd255, 8'd255, 8'd254, 1019, 254, 255);
      directed(0, 8'd0,   8'd0,   8'd0,   8'd0,   0,    0,   0);
      directed(1, 8'd8,   8'd8,   8'd8,   8'd8,   32,   8,   8);
      directed(0, 8'd77,  8'd66,  8'd55,  8'd44,  0,    0,   0);
      directed(1, 8'd1,   8'd2,   8'd3,   8'd5,   11,   2,   3);
      repeat (3) directed(0, 8'd0, 8'd0, 8'd0, 8'd0, 0, 0, 0);

      // Random regression against an arithmetic model of the mean.
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
         qa = 12'($urandom); qb = 12'($urandom); qc = 12'($urandom); qd = 12'($urandom);
         s8  = int'(ra) + int'(rb) + int'(rc) + int'(rd);
         s12 = int'(qa) + int'(qb) + int'(qc) + int'(qd);
         e.v = ($urandom_range(0, 3) != 0);
         e.sum = s8; e.avg0 = s8 / 4; e.avg1 = (s8 + 2) / 4;
         e.v12 = ($urandom_range(0, 3) != 0);
         e.sum12 = s12; e.avg12 = (s12 + 2) / 4;
         applyStimulus(ra, rb, rc, rd, qa, qb, qc, qd, e);
      end
      repeat (2) directed(0, 8'd0, 8'd0, 8'd0, 8'd0, 0, 0, 0);

      // Mid-flight reset: a result is on the outputs and another set is in stage 1.
      directed(1, 8'd10, 8'd20, 8'd30, 8'd40, 100, 25, 25);
      directed(1, 8'd4,  8'd4,  8'd4,  8'd4,  16,  4,  4);
      @(posedge clk);
      #2;
      checkOutput("rstPreValid", outValid0, 1);
      checkOutput("rstPreSum", sum0, 100);
      rst_n = 1'b0;
      inValid = 1'b0;
      inValid12 = 1'b0;
      #1;
      checkOutput("rstAsyncValid", outValid0, 0);
      checkOutput("rstAsyncSum", sum0, 0);
      checkOutput("rstAsyncAvg", avg0, 0);
      checkOutput("rstAsyncAvgR", avg1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      clearModel();
      repeat (3) directed(0, 8'd0, 8'd0, 8'd0, 8'd0, 0, 0, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
